prm_edge_mask_scan: RTL and testbench

// - Sequential driver and collector for a combinational PRM obstacle-check block (prm_oblgc_chk*).
// - Sweeps a range of 15-bit edge indices, presents each index on the checker query bus and samples edge_mask.
// - Packs the mask bits into WORD_W-bit words and streams them to the roadmap edge-mask memory writer over valid/ready.

---
 rtl/prm_edge_mask_scan.sv | 224 ++++++++++++++++++++++
 tb/tb_prm_edge_mask_scan.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/prm_edge_mask_scan.sv
// Sweeps an edge-index range through a PRM obstacle checker and packs the mask bits into output words.
// Optional build macro PRM_SCAN_POPCNT_EN adds blocked_cnt (count of 1 mask bits delivered this sweep).
module prm_edge_mask_scan #(
    parameter int IDX_W   = 15,
    parameter int WORD_W  = 32,
    parameter int CHK_LAT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [IDX_W-1:0]  start_idx,
    input  logic [IDX_W-1:0]  end_idx,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [IDX_W-1:0]  chk_query,
    input  logic              chk_mask,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
`ifdef PRM_SCAN_POPCNT_EN
    ,
    output logic [IDX_W:0]    blocked_cnt
`endif
);

    localparam int                FILL_W    = $clog2(WORD_W) + 1;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WORD_W);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
    localparam logic [IDX_W:0]    IDX_ONE   = (IDX_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_DRAIN = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [IDX_W:0]      idx_r, end_r;
    logic [FILL_W-1:0]   fill_r, inflight_r;
    logic [WORD_W-1:0]   pack_r, out_data_r;
    logic                out_valid_r, out_last_r, err_r, busy_r, done_r;
    logic                busy_nxt_s, done_nxt_s;
    logic                range_err_s, out_free_s, xfer_s, last_s, stall_s;
    logic                issue_s, issue_last_s, arrive_s;
    logic [FILL_W:0]     pending_s;

    assign range_err_s  = (end_idx < start_idx);
    assign out_free_s   = !out_valid_r || out_ready;
    assign pending_s    = {1'b0, fill_r} + {1'b0, inflight_r};
    // Hold issuing once every free pack slot is spoken for and the output word cannot leave
    assign stall_s      = out_valid_r && !out_ready && (pending_s >= {1'b0, FILL_FULL});
    assign issue_s      = (state_r == S_ISSUE) && !stall_s && !abort;
    assign issue_last_s = issue_s && (idx_r == end_r);
    // A word is final once no more queries can be issued and nothing is still returning
    assign last_s       = (state_r != S_ISSUE) && (inflight_r == '0);
    assign xfer_s       = out_free_s && ((fill_r == FILL_FULL) ||
                                         ((state_r == S_FLUSH) && (fill_r != '0)));
    assign chk_query    = idx_r[IDX_W-1:0];

    generate
        if (CHK_LAT == 0) begin : g_comb_chk
            assign arrive_s = issue_s;
        end else begin : g_pipe_chk
            logic [CHK_LAT-1:0] pipe_r;
            // Tag each issued query so its result is captured CHK_LAT cycles later
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe_r <= '0;
                end else if (abort) begin
                    pipe_r <= '0;
                end else begin
                    pipe_r[0] <= issue_s;
                    for (int i = 1; i < CHK_LAT; i++) begin
                        pipe_r[i] <= pipe_r[i-1];
                    end
                end
            end
            assign arrive_s = pipe_r[CHK_LAT-1];
        end
    endgenerate

    // State register with registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Next-state decode; abort overrides everything
    always_comb begin
        state_nxt_s = state_r;
        if (abort) begin
            state_nxt_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) state_nxt_s = range_err_s ? S_DONE : S_ISSUE;
                    else       state_nxt_s = S_IDLE;
                end
                S_ISSUE: begin
                    if (issue_last_s) state_nxt_s = S_DRAIN;
                    else              state_nxt_s = S_ISSUE;
                end
                S_DRAIN: begin
                    if (inflight_r == '0) state_nxt_s = S_FLUSH;
                    else                  state_nxt_s = S_DRAIN;
                end
                S_FLUSH: begin
                    if ((out_valid_r && out_last_r && out_ready) ||
                        ((fill_r == '0) && !out_valid_r)) state_nxt_s = S_DONE;
                    else                                   state_nxt_s = S_FLUSH;
                end
                S_DONE:  state_nxt_s = S_IDLE;
                default: state_nxt_s = S_IDLE;
            endcase
        end
    end

    // Status output decode from the upcoming state
    always_comb begin
        busy_nxt_s = (state_nxt_s != S_IDLE);
        done_nxt_s = (state_nxt_s == S_DONE);
    end

    // Index counter, result packing and the output word register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r       <= '0;
            end_r       <= '0;
            fill_r      <= '0;
            inflight_r  <= '0;
            pack_r      <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            err_r       <= 1'b0;
        end else if (abort) begin
            fill_r      <= '0;
            inflight_r  <= '0;
            pack_r      <= '0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if ((state_r == S_IDLE) && start) begin
            idx_r      <= {1'b0, start_idx};
            end_r      <= {1'b0, end_idx};
            err_r      <= range_err_s;
            fill_r     <= '0;
            inflight_r <= '0;
            pack_r     <= '0;
        end else begin
            if (issue_s) idx_r <= idx_r + IDX_ONE;
            case ({issue_s, arrive_s})
                2'b10:   inflight_r <= inflight_r + FILL_ONE;
                2'b01:   inflight_r <= inflight_r - FILL_ONE;
                default: inflight_r <= inflight_r;
            endcase
            // A result arriving with the transfer starts the next word at bit 0
            if (xfer_s) begin
                pack_r <= arrive_s ? {{(WORD_W-1){1'b0}}, chk_mask} : '0;
                fill_r <= arrive_s ? FILL_ONE : '0;
            end else if (arrive_s) begin
                pack_r[fill_r[FILL_W-2:0]] <= chk_mask;
                fill_r                     <= fill_r + FILL_ONE;
            end
            if (xfer_s) begin
                out_data_r  <= pack_r;
                out_valid_r <= 1'b1;
                out_last_r  <= last_s;
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
            end
        end
    end

`ifdef PRM_SCAN_POPCNT_EN
    function automatic logic [FILL_W-1:0] count_ones(input logic [WORD_W-1:0] v);
        logic [FILL_W-1:0] c;
        c = '0;
        for (int i = 0; i < WORD_W; i++) begin
            c = c + {{(FILL_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic [IDX_W:0] blocked_cnt_r;

    // Count only delivered words so pad bits and aborted results never contribute
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blocked_cnt_r <= '0;
        end else if (abort) begin
            blocked_cnt_r <= blocked_cnt_r;
        end else if ((state_r == S_IDLE) && start) begin
            blocked_cnt_r <= '0;
        end else if (out_valid_r && out_ready) begin
            blocked_cnt_r <= blocked_cnt_r + {{(IDX_W+1-FILL_W){1'b0}}, count_ones(out_data_r)};
        end else begin
            blocked_cnt_r <= blocked_cnt_r;
        end
    end

    assign blocked_cnt = blocked_cnt_r;
`endif

    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;

endmodule

// File: tb/tb_prm_edge_mask_scan.sv
// Scoreboard bench for prm_edge_mask_scan: a latency-matched checker model, reference word builder and output monitor.
module tb_prm_edge_mask_scan;

    localparam int IW  = 15;
    localparam int WW  = 32;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n, start, abort, busy, done, err, chk_mask;
    logic          out_valid, out_ready, out_last;
    logic [IW-1:0] start_idx, end_idx, chk_query;
    logic [WW-1:0] out_data;

    logic [IW-1:0] hist [0:LAT-1];
    logic [WW:0]   exp_q [$];
    logic [WW:0]   hold_w;
    logic          hold_v = 1'b0;
    logic [31:0]   seed = 32'd0;
    int            checks = 0, errors = 0;
    int            mode = 0, rdy_mode = 0, rdy_cnt = 0;
    int            cyc = 0, last_hs_cyc = 0, done_cnt = 0;

    prm_edge_mask_scan #(.IDX_W(IW), .WORD_W(WW), .CHK_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .start_idx(start_idx), .end_idx(end_idx),
        .busy(busy), .done(done), .err(err),
        .chk_query(chk_query), .chk_mask(chk_mask),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    always #5 clk = ~clk;

    function automatic logic mask_fn(input logic [IW-1:0] i, input int md, input logic [31:0] sd);
        logic [31:0] h;
        h = ({17'd0, i} * 32'h9E3779B1) ^ sd;
        case (md)
            0:       return 1'b1;
            1:       return i[0];
            2:       return h[13] ^ h[27] ^ h[5];
            default: return 1'b0;
        endcase
    endfunction

    // Checker model: the mask answers the query presented LAT cycles earlier
    always @(posedge clk) begin
        hist[0] <= chk_query;
        for (int i = 1; i < LAT; i++) hist[i] <= hist[i-1];
        cyc <= cyc + 1;
    end

    always_comb chk_mask = mask_fn(hist[LAT-1], mode, seed);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: edge start+k lands in word k/WW at bit k%WW; final word flagged last
    task automatic expect_sweep(input int s, input int e);
        logic [WW-1:0] w;
        int n;
        n = e - s + 1;
        w = '0;
        for (int k = 0; k < n; k++) begin
            w[k % WW] = mask_fn(IW'(s + k), mode, seed);
            if ((k % WW == WW - 1) || (k == n - 1)) begin
                exp_q.push_back({(k == n - 1), w});
                w = '0;
            end
        end
    endtask

    // Monitor: pops on each handshake and checks held words stay put
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (hold_v) check("hold_stable", {out_valid, out_last, out_data}, {1'b1, hold_w});
            hold_v = out_valid && !out_ready && !abort;
            hold_w = {out_last, out_data};
            if (out_valid && out_ready && !abort) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h expected no word", {out_last, out_data});
                end else begin
                    check("out_word", {out_last, out_data}, exp_q.pop_front());
                    last_hs_cyc = cyc;
                end
            end
        end
    end

    // Downstream ready pattern
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rdy_cnt++;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                2:       out_ready = (rdy_cnt > 40);
                3:       out_ready = ($urandom_range(0, 7) == 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic run_sweep(input int s, input int e, input int md, input int rm);
        int n;
        mode     = md;
        rdy_mode = rm;
        rdy_cnt  = 0;
        exp_q.delete();
        expect_sweep(s, e);
        @(posedge clk);
        #1;
        start_idx = IW'(s);
        end_idx   = IW'(e);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20000);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done (range %0d..%0d)", n, s, e);
        end else begin
            check("err_flag", err, (e < s));
            check("busy_in_done", busy, 1'b1);
            check("words_left", exp_q.size(), 0);
            if (e >= s) check("done_after_hs", cyc, last_hs_cyc + 1);
            @(negedge clk);
            check("done_width", done, 1'b0);
            check("busy_after", busy, 1'b0);
        end
        exp_q.delete();
    endtask

    initial begin
        int s, len, dc0, n;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        start_idx = '0; end_idx = '0;
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_chk_query", chk_query, 15'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_sweep(0, 31, 1, 0);
        run_sweep(5, 5, 0, 0);
        run_sweep(0, 99, 0, 2);
        run_sweep(32760, 32767, 0, 1);
        run_sweep(10, 3, 0, 0);
        check("err_sticky", err, 1'b1);
        run_sweep(100, 164, 2, 3);

        // Abort mid-sweep while a word waits on a stalled output
        mode = 0; rdy_mode = 4; rdy_cnt = 0;
        @(posedge clk);
        #1;
        start_idx = 15'd0; end_idx = 15'd299; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("abort_valid_pending", out_valid, 1'b1);
        check("abort_busy_before", busy, 1'b1);
        dc0 = done_cnt;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, dc0);

        for (int t = 0; t < 12; t++) begin
            seed = $urandom;
            s    = $urandom_range(0, 32767 - 300);
            len  = $urandom_range(1, 200);
            run_sweep(s, s + len - 1, (t % 4 == 0) ? int'($urandom_range(0, 3)) : 2,
                      int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish within 500000 time units");
        $fatal(1, "simulation timeout");
    end

endmodule
